// File: rtl/rr_arbiter_256_pkg.sv
// Shared types and defaults for the 256-way round-robin arbiter.
package rr_arbiter_256_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int N_DEF        = 256;
    localparam int MAX_HOLD_DEF = 16;

    // Minimum 1 bit so degenerate sizes still give a legal vector.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter_256_pick.sv
// Combinational round-robin pick: lowest set bit at or above ptr, else lowest set bit overall.
module rr_pick
    import rr_arbiter_256_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] winner,
    output logic          any
);

    logic [N-1:0]  mask;
    logic [N-1:0]  masked;
    logic [IW-1:0] m_idx;
    logic [IW-1:0] u_idx;
    logic          m_any;

    always_comb begin
        mask = '0;
        for (int i = 0; i < N; i++) begin
            mask[i] = (IW'(i) >= ptr);
        end
    end

    assign masked = req & mask;

    // Scanning downward lets the lowest set bit overwrite any higher one.
    always_comb begin
        m_idx = '0;
        u_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (masked[i]) m_idx = IW'(i);
            if (req[i])    u_idx = IW'(i);
        end
    end

    assign m_any  = |masked;
    assign any    = |req;
    assign winner = m_any ? m_idx : u_idx;

endmodule

// File: rtl/rr_arbiter_256.sv
// Round-robin arbiter holding a registered one-hot grant until done, owner drop or hold timeout.
module rr_arbiter_256
    import rr_arbiter_256_pkg::*;
#(
    parameter int N        = N_DEF,
    parameter int IW       = idx_w(N),
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          done,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_valid,
    output logic          preempt
);

    localparam int            CW       = idx_w(MAX_HOLD + 1);
    localparam logic [CW-1:0] HOLD_MAX = CW'(MAX_HOLD);
    localparam logic [CW-1:0] HOLD_SAT = (MAX_HOLD == 0) ? '1 : HOLD_MAX;

    state_t        state, state_d;
    logic [IW-1:0] ptr, ptr_d;
    logic [CW-1:0] hold_cnt, hold_cnt_d;
    logic [N-1:0]  gnt_d;
    logic [IW-1:0] gnt_idx_d;
    logic          gnt_valid_d;
    logic          preempt_d;

    logic [IW-1:0] win;
    logic          win_any;
    logic          owner_req;
    logic          timeout;
    logic          release_now;

    rr_pick #(.N(N), .IW(IW)) u_pick (
        .req    (req),
        .ptr    (ptr),
        .winner (win),
        .any    (win_any)
    );

    assign owner_req   = req[gnt_idx];
    assign timeout     = (MAX_HOLD != 0) && (hold_cnt == HOLD_MAX);
    assign release_now = done || !owner_req || timeout;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            hold_cnt  <= '0;
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            preempt   <= 1'b0;
        end else begin
            state     <= state_d;
            ptr       <= ptr_d;
            hold_cnt  <= hold_cnt_d;
            gnt       <= gnt_d;
            gnt_idx   <= gnt_idx_d;
            gnt_valid <= gnt_valid_d;
            preempt   <= preempt_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (win_any)     state_d = BUSY;
            BUSY:    if (release_now) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ptr_d       = ptr;
        hold_cnt_d  = hold_cnt;
        gnt_d       = gnt;
        gnt_idx_d   = gnt_idx;
        gnt_valid_d = gnt_valid;
        preempt_d   = 1'b0;
        case (state)
            IDLE: begin
                if (win_any) begin
                    gnt_d       = {{(N-1){1'b0}}, 1'b1} << win;
                    gnt_idx_d   = win;
                    gnt_valid_d = 1'b1;
                    hold_cnt_d  = CW'(1);
                end
            end
            BUSY: begin
                if (release_now) begin
                    gnt_d       = '0;
                    gnt_idx_d   = '0;
                    gnt_valid_d = 1'b0;
                    hold_cnt_d  = '0;
                    // Power-of-two N makes the index wrap for free.
                    ptr_d       = gnt_idx + IW'(1);
                    preempt_d   = timeout && !done && owner_req;
                end else if (hold_cnt != HOLD_SAT) begin
                    hold_cnt_d  = hold_cnt + CW'(1);
                end
            end
            default: begin
                gnt_d       = '0;
                gnt_idx_d   = '0;
                gnt_valid_d = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_rr_arbiter_256.sv
// Bench for rr_arbiter_256: directed table, hand sequences and a reference-model scoreboard.
module tb_rr_arbiter_256;

    localparam int N  = 256;
    localparam int MH = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         done;
    logic [N-1:0] req;
    logic [N-1:0] gnt;
    logic [7:0]   gnt_idx;
    logic         gnt_valid;
    logic         preempt;

    always #5 clk = ~clk;

    rr_arbiter_256 #(.N(N), .IW(8), .MAX_HOLD(MH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .preempt   (preempt)
    );

    typedef struct {
        logic       valid;
        logic [7:0] idx;
        logic       pre;
    } exp_t;

    typedef struct {
        logic [N-1:0] req;
        logic         done;
        logic         valid;
        logic [7:0]   idx;
        logic         pre;
    } vec_t;

    exp_t sbq[$];
    exp_t none;
    vec_t tbl[16];
    int   total = 0;
    int   bad   = 0;

    // Reference model: rotating scan from ptr, independent of mask/encoder structure.
    bit m_busy = 1'b0;
    bit m_pre  = 1'b0;
    int m_ptr  = 0;
    int m_cnt  = 0;
    int m_idx  = 0;

    task automatic model_step();
        bit found;
        bit drop;
        bit to;
        if (rst) begin
            m_busy = 1'b0; m_ptr = 0; m_cnt = 0; m_idx = 0; m_pre = 1'b0;
        end else if (!m_busy) begin
            m_pre = 1'b0;
            found = 1'b0;
            for (int j = 0; j < N; j++) begin
                if (!found && req[(m_ptr + j) % N]) begin
                    found = 1'b1;
                    m_busy = 1'b1;
                    m_idx = (m_ptr + j) % N;
                    m_cnt = 1;
                end
            end
        end else begin
            drop = !req[m_idx];
            to   = (MH != 0) && (m_cnt == MH);
            if (done || drop || to) begin
                m_pre  = to && !done && !drop;
                m_busy = 1'b0;
                m_ptr  = (m_idx + 1) % N;
                m_cnt  = 0;
            end else begin
                m_pre = 1'b0;
                if (m_cnt < MH) m_cnt++;
            end
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.valid = m_busy;
        e.idx   = m_busy ? 8'(m_idx) : 8'd0;
        e.pre   = m_pre;
        return e;
    endfunction

    task automatic check_v(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input string tag, input bit use_x, input exp_t x);
        exp_t         e;
        logic [N-1:0] oh;
        model_step();
        sbq.push_back(use_x ? x : model_out());
        @(posedge clk);
        #1;
        e  = sbq.pop_front();
        oh = '0;
        if (e.valid) oh[e.idx] = 1'b1;
        check_v({tag, " valid"},   N'(gnt_valid), N'(e.valid));
        check_v({tag, " idx"},     N'(gnt_idx),   N'(e.idx));
        check_v({tag, " preempt"}, N'(preempt),   N'(e.pre));
        check_v({tag, " gnt"},     gnt,           oh);
    endtask

    task automatic step(input string tag);
        tick(tag, 1'b0, none);
    endtask

    initial begin
        int           gcount;
        logic [N-1:0] seen;
        exp_t         x;

        none = '{1'b0, 8'd0, 1'b0};
        tbl[0]  = '{N'('h0C), 1'b0, 1'b1, 8'd2, 1'b0};
        tbl[1]  = '{N'('h0C), 1'b0, 1'b1, 8'd2, 1'b0};
        tbl[2]  = '{N'('h0C), 1'b1, 1'b0, 8'd0, 1'b0};
        tbl[3]  = '{N'('h0C), 1'b0, 1'b1, 8'd3, 1'b0};
        tbl[4]  = '{N'('h0C), 1'b0, 1'b1, 8'd3, 1'b0};
        tbl[5]  = '{N'('h0C), 1'b1, 1'b0, 8'd0, 1'b0};
        tbl[6]  = '{N'('h0C), 1'b0, 1'b1, 8'd2, 1'b0};
        tbl[7]  = '{N'('h0C), 1'b0, 1'b1, 8'd2, 1'b0};
        tbl[8]  = '{N'('h0C), 1'b1, 1'b0, 8'd0, 1'b0};
        tbl[9]  = '{N'('h00), 1'b1, 1'b0, 8'd0, 1'b0};
        tbl[10] = '{N'('h10), 1'b0, 1'b1, 8'd4, 1'b0};
        tbl[11] = '{N'('h00), 1'b0, 1'b0, 8'd0, 1'b0};
        tbl[12] = '{N'('h30), 1'b0, 1'b1, 8'd5, 1'b0};
        tbl[13] = '{N'('h10), 1'b0, 1'b0, 8'd0, 1'b0};
        tbl[14] = '{N'('h10), 1'b0, 1'b1, 8'd4, 1'b0};
        tbl[15] = '{N'('h10), 1'b1, 1'b0, 8'd0, 1'b0};

        rst = 1'b1; done = 1'b0; req = '0;
        step("reset");
        step("reset");
        rst = 1'b0;
        repeat (5) step("idle");

        for (int i = 0; i < 16; i++) begin
            req  = tbl[i].req;
            done = tbl[i].done;
            x    = '{tbl[i].valid, tbl[i].idx, tbl[i].pre};
            tick($sformatf("vec%0d", i), 1'b1, x);
        end

        // Full load with immediate release: strict 0..255 rotation.
        done = 1'b0; rst = 1'b1;
        step("all_rst");
        rst = 1'b0; req = '1;
        gcount = 0; seen = '0;
        for (int c = 0; c < 514; c++) begin
            done = m_busy;
            step("all");
            if (gnt_valid) begin
                check_v("all_order", N'(gnt_idx), N'(gcount % N));
                if (gcount < N) begin
                    check_v("all_repeat", N'(seen[gnt_idx]), N'(0));
                    seen[gnt_idx] = 1'b1;
                end
                gcount++;
            end
        end
        check_v("all_count", N'(gcount), N'(257));

        // Hold timeout on a lone requester, then timeout coinciding with done.
        done = 1'b0; rst = 1'b1;
        step("to_rst");
        rst = 1'b0; req = '0; req[7] = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step("to_hold");
            check_v("to_hold_idx", N'({gnt_valid, gnt_idx}), N'({1'b1, 8'd7}));
        end
        step("to_revoke");
        check_v("to_revoke", N'({gnt_valid, preempt}), N'(2'b01));
        step("to_regrant");
        check_v("to_regrant", N'({gnt_valid, preempt, gnt_idx}), N'({2'b10, 8'd7}));
        repeat (15) step("to_hold2");
        check_v("to_hold2", N'(gnt_valid), N'(1));
        done = 1'b1;
        step("to_coincide");
        check_v("to_coincide", N'({gnt_valid, preempt}), N'(2'b00));
        done = 1'b0;

        // Wrap-around from ptr=255 and release from the top index.
        rst = 1'b1;
        step("wr_rst");
        rst = 1'b0; req = '0; req[254] = 1'b1;
        step("wr_254");
        check_v("wr_254", N'(gnt_idx), N'(254));
        done = 1'b1; step("wr_rel254"); done = 1'b0;
        req = '0; req[1] = 1'b1; req[200] = 1'b1;
        step("wr_pick");
        check_v("wr_pick", N'(gnt_idx), N'(1));
        done = 1'b1; step("wr_rel1"); done = 1'b0;
        req = '0; req[255] = 1'b1;
        step("wr_255");
        check_v("wr_255", N'(gnt_idx), N'(255));
        done = 1'b1; step("wr_rel255"); done = 1'b0;
        req = '0; req[0] = 1'b1; req[255] = 1'b1;
        step("wr_ptr0");
        check_v("wr_ptr0", N'(gnt_idx), N'(0));
        done = 1'b1; step("wr_rel0"); done = 1'b0;

        // Reset mid-grant must also clear ptr.
        req = '0; req[7] = 1'b1;
        step("rm_7");
        done = 1'b1; step("rm_rel7"); done = 1'b0;
        req = '0; req[5] = 1'b1;
        step("rm_5");
        check_v("rm_5", N'(gnt_idx), N'(5));
        step("rm_hold");
        step("rm_hold");
        rst = 1'b1;
        step("rm_rst");
        check_v("rm_rst", N'({gnt_valid, preempt, |gnt}), N'(3'b000));
        rst = 1'b0; req[9] = 1'b1;
        step("rm_after");
        check_v("rm_after", N'(gnt_idx), N'(5));

        // Random traffic scored against the model.
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 5) == 0) begin
                req = '0;
                if ($urandom_range(0, 4) != 0) begin
                    for (int b = 0; b < int'($urandom_range(1, 4)); b++) begin
                        req[$urandom_range(0, N - 1)] = 1'b1;
                    end
                end
            end
            done = ($urandom_range(0, 19) == 0);
            rst  = ($urandom_range(0, 199) == 0);
            step("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rr_arbiter_256.md
# rr_arbiter_256

Round-robin arbiter that shares one resource among up to 256 requesters. A masked lowest-index-first priority pick selects the winner. The block then holds a registered one-hot grant plus its 8-bit binary index until the owner releases the resource or a hold timeout expires. It sits in front of the shared resource and drives its select lines, in the same one-hot/index form the priority-encoder and encoder pair produces.

## Interface
- N, 256: number of requesters; must be a power of two, 2..256.
- IW, $clog2(N): width of the grant index.
- MAX_HOLD, 16: maximum number of cycles one grant may be held; 0 disables the timeout.
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- req  in  N  request vector; bit i high means requester i wants the resource.
- done  in  1  release pulse from the current owner; ignored while no grant is active.
- gnt  out  N  registered one-hot grant; all zero when idle.
- gnt_idx  out  IW  binary index of the set bit in gnt; 0 when idle.
- gnt_valid  out  1  high exactly when gnt is non-zero.
- preempt  out  1  one-cycle pulse on the cycle a grant is revoked by timeout.

## Operation
- FSM has two states: IDLE and BUSY. Reset enters IDLE with ptr=0, gnt=0, gnt_idx=0, gnt_valid=0, preempt=0 and hold counter=0.
- Pick rule:
  - Form mask = bits ≥ ptr, then masked = req & mask.
  - If masked is non-zero, the winner is the lowest set bit of masked.
  - Otherwise the winner is the lowest set bit of req.
  - If req is 0, there is no winner.
- IDLE, winner exists: register gnt=onehot(winner), gnt_idx=winner, gnt_valid=1, hold counter=1, then go to BUSY.
- IDLE, req=0: stay in IDLE; outputs stay zero.
- BUSY has three release causes:
  - done=1;
  - req[gnt_idx]=0, meaning the owner dropped its request;
  - MAX_HOLD≠0 and hold counter==MAX_HOLD.
- BUSY, any release cause: at the next edge clear gnt, gnt_idx and gnt_valid, set ptr=(gnt_idx+1) mod N, and go to IDLE.
- preempt=1 for that one cycle only when the timeout is the sole cause. If done or a request drop coincides with the timeout, this counts as a normal release and preempt stays 0.
- BUSY, no release cause: hold all outputs and increment the hold counter. The counter saturates at MAX_HOLD.
- Wrap-around: ptr=N-1 with req bit N-1 clear wraps the pick to the lowest set bit overall. Releasing from index N-1 sets ptr=0.
- Changes to req bits other than the owner's are ignored while in BUSY.

## Timing
- Grant latency is 1 cycle: req sampled at edge k gives gnt_valid high after edge k.
- Release latency is 1 cycle: a release cause sampled at edge k gives gnt=0 after edge k.
- There is always at least one IDLE cycle between consecutive grants, so the fastest a requester can be regranted is every 2 cycles.
- preempt is registered and is high during the IDLE cycle that follows the revocation.
- gnt, gnt_idx and gnt_valid change only at clock edges and never glitch between grants.
- Reset asserted mid-grant: outputs are zero after that edge and ptr=0. No preempt pulse is issued.
- Fairness: under continuous requests from all N requesters, each is granted exactly once every N grants.

## Structure
- Shared package contents:
  - state enum {IDLE, BUSY};
  - default constants N_DEF=256 and MAX_HOLD_DEF=16;
  - an index-width function used for IW.
- Sub-module rr_pick: purely combinational.
  - Inputs: req and ptr. Outputs: winner index and any.
  - Implementation: two lowest-index-first N-bit priority encoders (masked and unmasked) plus a 2:1 mux.
  - Keep it separately testable.
- Top level contains only the FSM, ptr register, hold counter and output registers.

## Test plan
- Reset, then req=0 for 5 cycles: gnt=0, gnt_valid=0 and preempt=0 throughout.
- req=0x...0C (bits 2 and 3), owners release with done after 2 cycles each: grants go idx 2, then idx 3, then idx 2, each with a 1-cycle IDLE gap between them.
- All 256 bits of req held high with done every cycle in BUSY: gnt_idx runs 0,1,…,255,0, and no index repeats within 256 grants.
- req bit 7 only, no done, MAX_HOLD=16: gnt_idx=7 for 16 cycles, then one cycle with gnt=0 and preempt=1, then 7 is regranted.
- ptr=255 (after releasing idx 254), req bits 1 and 200 set: winner is idx 1 via wrap. After releasing idx 255, ptr=0.
- rst asserted while gnt_idx=5 is held: the next cycle shows gnt=0, gnt_valid=0, preempt=0. After rst falls with req bits 5 and 9 set, idx 5 is granted, confirming ptr=0.
